// File: rtl/core_v_mini_mcu_pkg.sv
// rtl/core_v_mini_mcu_pkg.sv - MCU-level shared types
package core_v_mini_mcu_pkg;

    // Requester identity on the merged CPU OBI port
    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } obi_arb_src_e;

endpackage

// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI request/response bundle types
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/cpu_obi_arb_id_fifo.sv
// rtl/cpu_obi_arb_id_fifo.sv - in-order requester ID FIFO for outstanding OBI transactions
module cpu_obi_arb_id_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         push_id_i,
    input  logic                         pop_i,
    output logic                         head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Explicit wrap so non-power-of-two depths never index past the last slot
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        if (ptr == PW'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PW'(1);
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

    // Storage, pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= push_id_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (do_pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/cpu_obi_port_arbiter.sv
// rtl/cpu_obi_port_arbiter.sv - round-robin merge of CPU instr/data OBI ports onto one bus port
module cpu_obi_port_arbiter
    import obi_pkg::*;
    import core_v_mini_mcu_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  obi_req_t                               core_instr_req_i,
    output obi_resp_t                              core_instr_resp_o,
    input  obi_req_t                               core_data_req_i,
    output obi_resp_t                              core_data_resp_o,
    output obi_req_t                               bus_req_o,
    input  obi_resp_t                              bus_resp_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    obi_arb_src_e sel;
    obi_arb_src_e last_q;
    obi_arb_src_e lock_src_q;
    obi_arb_src_e head_src;
    logic         lock_q;
    logic         err_q;
    obi_req_t     sel_req;
    logic         handshake;
    logic         resp_pop;
    logic         fifo_head;
    logic         fifo_full;
    logic         fifo_empty;
    logic [$clog2(MAX_OUTSTANDING+1)-1:0] fifo_count;

    // Source choice: a locked address phase wins, then a lone requester, then round-robin
    always_comb begin
        sel = SRC_INSTR;
        if (lock_q) begin
            sel = lock_src_q;
        end else if (core_instr_req_i.req && !core_data_req_i.req) begin
            sel = SRC_INSTR;
        end else if (!core_instr_req_i.req && core_data_req_i.req) begin
            sel = SRC_DATA;
        end else if (core_instr_req_i.req && core_data_req_i.req) begin
            sel = (last_q == SRC_INSTR) ? SRC_DATA : SRC_INSTR;
        end
    end

    assign sel_req = (sel == SRC_DATA) ? core_data_req_i : core_instr_req_i;

    // Forward the selected request; a full ID FIFO blocks issue even if a pop is happening
    always_comb begin
        bus_req_o     = sel_req;
        bus_req_o.req = sel_req.req & ~fifo_full & rst_ni;
    end

    assign handshake = bus_req_o.req & bus_resp_i.gnt;
    assign resp_pop  = bus_resp_i.rvalid & ~fifo_empty & rst_ni;
    assign head_src  = obi_arb_src_e'(fifo_head);

    // Grant only to the selected port, rvalid only to the port at the FIFO head, rdata broadcast
    always_comb begin
        core_instr_resp_o.gnt    = handshake & (sel == SRC_INSTR);
        core_instr_resp_o.rvalid = resp_pop & (head_src == SRC_INSTR);
        core_instr_resp_o.rdata  = bus_resp_i.rdata;
        core_data_resp_o.gnt     = handshake & (sel == SRC_DATA);
        core_data_resp_o.rvalid  = resp_pop & (head_src == SRC_DATA);
        core_data_resp_o.rdata   = bus_resp_i.rdata;
    end

    // Address-phase lock and round-robin history
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q     <= 1'b0;
            lock_src_q <= SRC_INSTR;
            last_q     <= SRC_DATA;
        end else if (handshake) begin
            lock_q <= 1'b0;
            last_q <= sel;
        end else if (bus_req_o.req) begin
            lock_q     <= 1'b1;
            lock_src_q <= sel;
        end
    end

    // Sticky error on a response that has no matching outstanding transaction
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (bus_resp_i.rvalid && fifo_empty) begin
            err_q <= 1'b1;
        end
    end

    cpu_obi_arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push_i    (handshake),
        .push_id_i (sel),
        .pop_i     (resp_pop),
        .head_o    (fifo_head),
        .count_o   (fifo_count),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    assign outstanding_o = fifo_count;
    assign err_o         = err_q;

endmodule

// File: tb/tb_cpu_obi_port_arbiter.sv
// tb/tb_cpu_obi_port_arbiter.sv - scoreboard bench for the CPU OBI port arbiter
module tb_cpu_obi_port_arbiter;
    import obi_pkg::*;

    localparam int MAXO = 2;
    localparam int OW   = $clog2(MAXO + 1);

    logic          clk;
    logic          rst_n;
    obi_req_t      instr_req;
    obi_req_t      data_req;
    obi_req_t      bus_req;
    obi_resp_t     instr_resp;
    obi_resp_t     data_resp;
    obi_resp_t     bus_resp;
    logic [OW-1:0] outstanding;
    logic          err;

    int n_checks;
    int n_errors;

    // Reference model: counts, queues and a few flags derived from the arbitration rules
    int  m_cnt;
    bit  m_lock;
    bit  m_lock_src;
    bit  m_last;
    bit  m_err;
    bit  m_igr;
    bit  m_dgr;
    int  push_pending;
    bit  exp_q[$];
    bit  glog[$];
    bit  mon_p;

    cpu_obi_port_arbiter #(
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .core_instr_req_i  (instr_req),
        .core_instr_resp_o (instr_resp),
        .core_data_req_i   (data_req),
        .core_data_resp_o  (data_resp),
        .bus_req_o         (bus_req),
        .bus_resp_i        (bus_resp),
        .outstanding_o     (outstanding),
        .err_o             (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_check();
        bit       ir;
        bit       dr;
        bit       sel;
        bit       breq;
        bit       hs;
        obi_req_t sr;
        ir = instr_req.req;
        dr = data_req.req;
        if (!rst_n) begin
            chk("rst_bus_req", bus_req.req, 0);
            chk("rst_gnt", {instr_resp.gnt, data_resp.gnt}, 0);
            chk("rst_outstanding", outstanding, 0);
            chk("rst_err", err, 0);
            m_cnt = 0; m_lock = 0; m_lock_src = 0; m_last = 1; m_err = 0;
            m_igr = 0; m_dgr = 0; push_pending = -1;
            exp_q.delete();
            return;
        end
        if (m_lock)          sel = m_lock_src;
        else if (ir && !dr)  sel = 0;
        else if (dr && !ir)  sel = 1;
        else if (ir && dr)   sel = ~m_last;
        else                 sel = 0;
        sr   = sel ? data_req : instr_req;
        breq = sr.req && (m_cnt < MAXO);
        hs   = breq && bus_resp.gnt;
        chk("bus_req", bus_req.req, breq);
        if (breq)
            chk("bus_payload", {bus_req.we, bus_req.be, bus_req.addr, bus_req.wdata},
                {sr.we, sr.be, sr.addr, sr.wdata});
        chk("instr_gnt", instr_resp.gnt, hs && !sel);
        chk("data_gnt", data_resp.gnt, hs && sel);
        chk("outstanding", outstanding, m_cnt);
        chk("err", err, m_err);
        m_igr = hs && !sel;
        m_dgr = hs && sel;
        if (hs) glog.push_back(sel);
        if (bus_resp.rvalid) begin
            if (m_cnt > 0) m_cnt--;
            else           m_err = 1;
        end
        if (hs) begin
            m_cnt++;
            push_pending = int'(sel);
            m_last = sel;
            m_lock = 0;
        end else if (breq) begin
            m_lock = 1;
            m_lock_src = sel;
        end
    endtask

    // Monitor: every core-side rvalid must match the oldest expected response
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rvalid_in_reset", {instr_resp.rvalid, data_resp.rvalid}, 0);
        end else if (bus_resp.rvalid && exp_q.size() > 0) begin
            mon_p = exp_q.pop_front();
            chk("rvalid_route", {instr_resp.rvalid, data_resp.rvalid}, mon_p ? 2'b01 : 2'b10);
            chk("rdata_instr", instr_resp.rdata, bus_resp.rdata);
            chk("rdata_data", data_resp.rdata, bus_resp.rdata);
        end else begin
            chk("rvalid_idle", {instr_resp.rvalid, data_resp.rvalid}, 2'b00);
        end
    end

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (push_pending >= 0) begin
            exp_q.push_back(push_pending[0]);
            push_pending = -1;
        end
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    task automatic drv(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                       input bit g, input bit rv, input logic [31:0] rd);
        instr_req.req   = ir;
        instr_req.we    = 1'b0;
        instr_req.be    = 4'hF;
        instr_req.addr  = ia;
        instr_req.wdata = 32'h0;
        data_req.req    = dr;
        data_req.we     = 1'b0;
        data_req.be     = 4'hF;
        data_req.addr   = da;
        data_req.wdata  = 32'h0;
        bus_resp.gnt    = g;
        bus_resp.rvalid = rv;
        bus_resp.rdata  = rd;
    endtask

    initial begin
        bit ir_on;
        bit dr_on;
        n_checks = 0;
        n_errors = 0;
        push_pending = -1;
        m_cnt = 0; m_lock = 0; m_lock_src = 0; m_last = 1; m_err = 0;
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single source data read
        drv(0, 0, 1, 32'h1000, 1, 0, 0);
        settle();
        chk("t1_data_gnt", data_resp.gnt, 1);
        advance();
        drv(0, 0, 0, 0, 0, 1, 32'hDEADBEEF);
        settle();
        chk("t1_data_rvalid", data_resp.rvalid, 1);
        chk("t1_rdata", data_resp.rdata, 32'hDEADBEEF);
        chk("t1_instr_rvalid", instr_resp.rvalid, 0);
        chk("t1_outstanding_1", outstanding, 1);
        advance();
        drv(0, 0, 0, 0, 0, 0, 0);
        settle();
        chk("t1_outstanding_0", outstanding, 0);
        advance();

        // Tie round-robin
        glog.delete();
        for (int k = 0; k < 4; k++) begin
            drv(1, 32'h2000, 1, 32'h3000, 1, k > 0, 32'hA000 + k);
            cyc();
        end
        drv(0, 0, 0, 0, 0, 1, 32'hA004);
        cyc();
        chk("tie_count", glog.size(), 4);
        if (glog.size() == 4) chk("tie_order", {glog[0], glog[1], glog[2], glog[3]}, 4'b0101);

        // Lock on withheld grant
        glog.delete();
        drv(1, 32'h4000, 0, 0, 0, 0, 0);
        settle(); chk("lock_addr0", bus_req.addr, 32'h4000); advance();
        for (int k = 1; k < 3; k++) begin
            drv(1, 32'h4000, 1, 32'h5000, 0, 0, 0);
            settle(); chk("lock_addr", bus_req.addr, 32'h4000); advance();
        end
        drv(1, 32'h4000, 1, 32'h5000, 1, 0, 0);
        settle(); chk("lock_instr_gnt", instr_resp.gnt, 1); advance();
        drv(0, 0, 1, 32'h5000, 1, 1, 32'hB000);
        cyc();
        drv(0, 0, 0, 0, 0, 1, 32'hB001);
        cyc();
        chk("lock_count", glog.size(), 2);
        if (glog.size() == 2) chk("lock_order", {glog[0], glog[1]}, 2'b01);

        // Full ID FIFO
        drv(1, 32'h6000, 0, 0, 1, 0, 0);
        cyc();
        drv(0, 0, 1, 32'h7000, 1, 0, 0);
        cyc();
        drv(1, 32'h6004, 0, 0, 1, 0, 0);
        settle();
        chk("full_bus_req", bus_req.req, 0);
        chk("full_outstanding", outstanding, 2);
        advance();
        drv(1, 32'h6004, 0, 0, 1, 1, 32'hC000);
        settle();
        chk("full_pop_no_gnt", instr_resp.gnt, 0);
        chk("full_pop_rvalid", instr_resp.rvalid, 1);
        advance();
        drv(1, 32'h6004, 0, 0, 1, 1, 32'hC001);
        settle(); chk("full_next_gnt", instr_resp.gnt, 1); advance();
        drv(0, 0, 0, 0, 0, 1, 32'hC002);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0);
        settle(); chk("full_drained", outstanding, 0); advance();

        // Spurious response
        drv(0, 0, 0, 0, 0, 1, 32'h1234);
        settle();
        chk("spur_rvalid", {instr_resp.rvalid, data_resp.rvalid}, 2'b00);
        advance();
        drv(0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            settle(); chk("spur_err_sticky", err, 1); advance();
        end
        rst_n = 1'b0;
        settle(); chk("spur_err_cleared", err, 0); advance();
        rst_n = 1'b1;
        cyc();

        // Reset mid-flight
        drv(0, 0, 1, 32'h8000, 1, 0, 0);
        cyc();
        drv(1, 32'h9000, 0, 0, 1, 0, 0);
        cyc();
        rst_n = 1'b0;
        drv(1, 32'h9004, 1, 32'h8004, 1, 0, 0);
        settle();
        chk("mid_rst_outstanding", outstanding, 0);
        chk("mid_rst_handshake", {bus_req.req, instr_resp.gnt, data_resp.gnt}, 0);
        advance();
        rst_n = 1'b1;
        drv(0, 0, 0, 0, 0, 1, 32'hD000);
        settle(); chk("stale_rvalid", {instr_resp.rvalid, data_resp.rvalid}, 2'b00); advance();
        drv(1, 32'h9008, 1, 32'h8008, 1, 0, 0);
        settle();
        chk("stale_err", err, 1);
        chk("post_rst_tie_instr", {instr_resp.gnt, data_resp.gnt}, 2'b10);
        advance();
        drv(0, 0, 0, 0, 0, 1, 32'hD001);
        cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;

        // Randomized traffic
        ir_on = 0;
        dr_on = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!ir_on || m_igr) begin
                ir_on = 1'($urandom_range(0, 1));
                instr_req.addr  = $urandom & 32'hFFFF_FFFC;
                instr_req.we    = 1'b0;
                instr_req.be    = 4'hF;
                instr_req.wdata = 32'h0;
            end
            if (!dr_on || m_dgr) begin
                dr_on = 1'($urandom_range(0, 1));
                data_req.addr  = $urandom;
                data_req.we    = 1'($urandom_range(0, 1));
                data_req.be    = 4'($urandom_range(0, 15));
                data_req.wdata = $urandom;
            end
            instr_req.req   = ir_on;
            data_req.req    = dr_on;
            bus_resp.gnt    = ($urandom_range(0, 3) != 0);
            bus_resp.rvalid = (m_cnt > 0) && ($urandom_range(0, 2) != 0);
            bus_resp.rdata  = $urandom;
            cyc();
        end
        instr_req.req = 1'b0;
        data_req.req  = 1'b0;
        bus_resp.gnt  = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus_resp.rvalid = (m_cnt > 0);
            bus_resp.rdata  = $urandom;
            cyc();
        end
        bus_resp.rvalid = 1'b0;
        settle();
        chk("final_outstanding", outstanding, 0);
        chk("final_scoreboard_empty", exp_q.size(), 0);
        chk("final_err", err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
